l1_l2_port_arbiter: RTL and testbench
=====================================

// Module: l1_l2_port_arbiter
// PURPOSE
//  Shares the single L2 line port between the instruction L1 (port I) and the data L1 (port D).
//  - Selects one requester by round-robin and forwards its typed line request downstream.
//  - Holds that grant until L2 raises mem_ready, then returns the line to the granted L1 only.
//  - Sits between the two cache_L1 instances and L2; each side uses the cache_L1 L2-interface
//    signalling unchanged.
// PARAMETERS
//  CACHE_LINE_SIZE  512    line width in bits; must equal the L1/L2 line width
//  TIMEOUT_CYCLES   1024   grant cycles without mem_ready before timeout_err sets
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 reset, asynchronous, active-high
//  i_load_type      in   mem_load_type_t   port I load request (NO_LOAD = none)
//  i_store_type     in   mem_store_type_t  port I store request (NO_STORE = none)
//  i_addr           in   64                port I line address
//  i_wdata          in   CACHE_LINE_SIZE   port I write-back line
//  i_rdata          out  CACHE_LINE_SIZE   line returned to port I
//  i_ready          out  1                 completion pulse to port I
//  d_load_type      in   mem_load_type_t   port D load request
//  d_store_type     in   mem_store_type_t  port D store request
//  d_addr           in   64                port D line address
//  d_wdata          in   CACHE_LINE_SIZE   port D write-back line
//  d_rdata          out  CACHE_LINE_SIZE   line returned to port D
//  d_ready          out  1                 completion pulse to port D
//  mem_load_type    out  mem_load_type_t   request to L2
//  mem_store_type   out  mem_store_type_t  request to L2
//  mem_addr         out  64                address to L2
//  mem_wdata        out  CACHE_LINE_SIZE   write data to L2
//  mem_rdata        in   CACHE_LINE_SIZE   line from L2
//  mem_ready        in   1                 L2 completion, one cycle
//  timeout_err      out  1                 sticky timeout flag
// BEHAVIOUR
//  Request and priority
//  - Port X is requesting when x_load_type != NO_LOAD or x_store_type != NO_STORE.
//  - Each L1 holds its request level-stable until it sees x_ready.
//  - rr_prio: 0 = port D preferred, 1 = port I preferred.
//  Reset
//  - state = IDLE; rr_prio = 0 (D preferred); timeout_err = 0; timer = 0.
//  - mem_load_type = NO_LOAD; mem_store_type = NO_STORE; mem_addr = 0; mem_wdata = 0.
//  - i_ready = 0; d_ready = 0.
//  - Reset mid-grant abandons the transaction; no ready pulse is issued to either port.
//  FSM states: IDLE, GRANT_I, GRANT_D.
//  IDLE
//  - Only one port requesting: grant it.
//  - Both requesting: grant the port selected by rr_prio.
//  - On the grant edge, register that port's load type, store type, addr and wdata onto the
//    mem_* outputs, then enter GRANT_x.
//  - Downstream request is therefore visible exactly 1 cycle after the request is seen.
//  - Neither port requesting: mem_* request outputs stay at NO_LOAD / NO_STORE.
//  - A load and a store together from one port are forwarded unchanged; the arbiter does not split them.
//  GRANT_x
//  - mem_* outputs hold the latched copy; requester-input changes are ignored.
//  - The other port waits; its ready stays 0.
//  - Timer increments each cycle. When the timer reaches TIMEOUT_CYCLES, timeout_err sets and
//    stays set until rst. The timer saturates and the grant is not aborted.
//  mem_ready while in GRANT_x
//  - x_ready = mem_ready (combinational, same cycle).
//  - At that edge: state becomes IDLE, mem_* return to NO_LOAD / NO_STORE, timer clears, and
//    rr_prio moves to point at the other port.
//  - The earliest re-grant comes from IDLE on the following cycle, so there is 1 idle cycle
//    between transactions.
//  - An L1 issuing a back-to-back write-back followed by a refill re-arbitrates each phase
//    independently.
//  Read data and ready gating
//  - i_rdata = d_rdata = mem_rdata, combinational, always. Only the granted port's ready qualifies it.
//  - mem_ready in IDLE is ignored: no ready pulse, no state change.
//  - i_ready = d_ready = 0 outside their GRANT state.
// TESTING
//  1. Single D load at addr 0x1000 -> mem_load_type = LOAD_DWORD and mem_addr = 0x1000 on the
//     next cycle; L2 ready 3 cycles later -> d_ready pulses 1 cycle with d_rdata = mem_rdata;
//     i_ready stays 0.
//  2. I and D request in the same cycle after reset -> D granted first; after D's mem_ready,
//     IDLE for 1 cycle, then I granted with mem_addr = i_addr.
//  3. Both ports request continuously for 4 transactions -> grants alternate D, I, D, I.
//  4. D issues a dirty write-back STORE_DWORD at 0x2000 with wdata pattern A5.. -> mem_wdata
//     matches; changing d_wdata mid-grant leaves mem_wdata unchanged.
//  5. TIMEOUT_CYCLES = 8, mem_ready withheld -> timeout_err = 1 after 8 grant cycles and stays 1
//     after the later mem_ready.
//  6. rst asserted during GRANT_I -> all outputs at reset values immediately; a mem_ready after
//     rst release produces no i_ready.

Source files
------------

// File: rtl/l1_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the instruction L1 (I) and data L1 (D).
// A grant is held until L2 signals mem_ready; the granted request is latched onto the mem_* outputs.
package l1_l2_port_arbiter_pkg;
    typedef enum logic [2:0] {
        NO_LOAD,
        LOAD_BYTE,
        LOAD_HALF,
        LOAD_WORD,
        LOAD_DWORD
    } mem_load_type_t;

    typedef enum logic [2:0] {
        NO_STORE,
        STORE_BYTE,
        STORE_HALF,
        STORE_WORD,
        STORE_DWORD
    } mem_store_type_t;
endpackage

module l1_l2_port_arbiter
    import l1_l2_port_arbiter_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = 512,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  mem_load_type_t             i_load_type,
    input  mem_store_type_t            i_store_type,
    input  logic [63:0]                i_addr,
    input  logic [CACHE_LINE_SIZE-1:0] i_wdata,
    output logic [CACHE_LINE_SIZE-1:0] i_rdata,
    output logic                       i_ready,
    input  mem_load_type_t             d_load_type,
    input  mem_store_type_t            d_store_type,
    input  logic [63:0]                d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] d_wdata,
    output logic [CACHE_LINE_SIZE-1:0] d_rdata,
    output logic                       d_ready,
    output mem_load_type_t             mem_load_type,
    output mem_store_type_t            mem_store_type,
    output logic [63:0]                mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
    input  logic [CACHE_LINE_SIZE-1:0] mem_rdata,
    input  logic                       mem_ready,
    output logic                       timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } state_t;

    state_t                     state_reg, state_next;
    logic                       rr_prio_reg, rr_prio_next;
    logic [TW-1:0]              timer_reg, timer_next;
    logic                       timeout_err_reg, timeout_err_next;
    mem_load_type_t             load_reg, load_next;
    mem_store_type_t            store_reg, store_next;
    logic [63:0]                addr_reg, addr_next;
    logic [CACHE_LINE_SIZE-1:0] wdata_reg, wdata_next;

    logic i_req;
    logic d_req;

    assign i_req = (i_load_type != NO_LOAD) || (i_store_type != NO_STORE);
    assign d_req = (d_load_type != NO_LOAD) || (d_store_type != NO_STORE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rr_prio_reg     <= 1'b0;
            timer_reg       <= '0;
            timeout_err_reg <= 1'b0;
            load_reg        <= NO_LOAD;
            store_reg       <= NO_STORE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            rr_prio_reg     <= rr_prio_next;
            timer_reg       <= timer_next;
            timeout_err_reg <= timeout_err_next;
            load_reg        <= load_next;
            store_reg       <= store_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rr_prio_next     = rr_prio_reg;
        timer_next       = timer_reg;
        timeout_err_next = timeout_err_reg;
        load_next        = load_reg;
        store_next       = store_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;

        case (state_reg)
            IDLE: begin
                // rr_prio only matters when both ports contend
                if (i_req && (!d_req || rr_prio_reg)) begin
                    state_next = GRANT_I;
                    load_next  = i_load_type;
                    store_next = i_store_type;
                    addr_next  = i_addr;
                    wdata_next = i_wdata;
                    timer_next = '0;
                end else if (d_req) begin
                    state_next = GRANT_D;
                    load_next  = d_load_type;
                    store_next = d_store_type;
                    addr_next  = d_addr;
                    wdata_next = d_wdata;
                    timer_next = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_next   = IDLE;
                    load_next    = NO_LOAD;
                    store_next   = NO_STORE;
                    timer_next   = '0;
                    rr_prio_next = (state_reg == GRANT_D);
                end else if (timer_reg != TW'(TIMEOUT_CYCLES)) begin
                    // Flag is raised on the edge where the timer reaches the limit
                    timer_next = timer_reg + TW'(1);
                    if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign i_ready        = (state_reg == GRANT_I) && mem_ready;
    assign d_ready        = (state_reg == GRANT_D) && mem_ready;
    assign i_rdata        = mem_rdata;
    assign d_rdata        = mem_rdata;
    assign mem_load_type  = load_reg;
    assign mem_store_type = store_reg;
    assign mem_addr       = addr_reg;
    assign mem_wdata      = wdata_reg;
    assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_l1_l2_port_arbiter.sv
// Randomized bench for l1_l2_port_arbiter: L1/L2 agents drive traffic, a transaction-level
// model predicts grants, latched requests, ready pulses and the timeout flag every cycle.
module tb_l1_l2_port_arbiter;
    import l1_l2_port_arbiter_pkg::*;

    localparam int W  = 512;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    mem_load_type_t  i_load_type = NO_LOAD, d_load_type = NO_LOAD;
    mem_store_type_t i_store_type = NO_STORE, d_store_type = NO_STORE;
    logic [63:0]     i_addr = '0, d_addr = '0;
    logic [W-1:0]    i_wdata = '0, d_wdata = '0;
    logic [W-1:0]    i_rdata, d_rdata;
    logic            i_ready, d_ready;
    mem_load_type_t  mem_load_type;
    mem_store_type_t mem_store_type;
    logic [63:0]     mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata = '0;
    logic            mem_ready = 1'b0;
    logic            timeout_err;

    l1_l2_port_arbiter #(.CACHE_LINE_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_load_type(i_load_type), .i_store_type(i_store_type), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_load_type(d_load_type), .d_store_type(d_store_type), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: owner 0 = none, 1 = I, 2 = D
    int              owner;
    bit              prefer_i;
    int              gcycles;
    bit              m_err;
    bit              m_hold_valid;
    bit              granted_now;
    mem_load_type_t  m_load;
    mem_store_type_t m_store;
    logic [63:0]     m_addr;
    logic [W-1:0]    m_wdata;
    int              rdy_log[$];

    // Agent knobs and state
    bit auto_l1 = 0, keep_busy = 0, perturb = 0, hold_l2 = 0;
    int lat_lo = 0, lat_hi = 0, idle_pct = 0, lat_cnt = 0;
    bit seen_i, seen_d;

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void model_reset();
        owner = 0; prefer_i = 0; gcycles = 0; m_err = 0; granted_now = 0;
        m_load = NO_LOAD; m_store = NO_STORE; m_addr = '0; m_wdata = '0; m_hold_valid = 1;
    endfunction

    function automatic void model_update();
        bit ir, dr;
        ir = (i_load_type != NO_LOAD) || (i_store_type != NO_STORE);
        dr = (d_load_type != NO_LOAD) || (d_store_type != NO_STORE);
        granted_now = 0;
        if (owner == 0) begin
            if (ir && (!dr || prefer_i)) begin
                owner = 1; m_load = i_load_type; m_store = i_store_type;
                m_addr = i_addr; m_wdata = i_wdata;
            end else if (dr) begin
                owner = 2; m_load = d_load_type; m_store = d_store_type;
                m_addr = d_addr; m_wdata = d_wdata;
            end
            if (owner != 0) begin
                gcycles = 0; granted_now = 1; m_hold_valid = 1;
            end
        end else if (mem_ready) begin
            prefer_i = (owner == 2);
            owner = 0; m_load = NO_LOAD; m_store = NO_STORE; m_hold_valid = 0;
        end else begin
            if (gcycles < TO) gcycles++;
            if (gcycles == TO) m_err = 1;
        end
    endfunction

    task automatic check_outputs();
        check_val("mem_load_type", mem_load_type, m_load);
        check_val("mem_store_type", mem_store_type, m_store);
        if (m_hold_valid) begin
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_wdata", mem_wdata, m_wdata);
        end
        check_val("i_ready", i_ready, (owner == 1) && mem_ready);
        check_val("d_ready", d_ready, (owner == 2) && mem_ready);
        check_val("i_rdata", i_rdata, mem_rdata);
        check_val("d_rdata", d_rdata, mem_rdata);
        check_val("timeout_err", timeout_err, m_err);
    endtask

    task automatic new_req(output mem_load_type_t ld, output mem_store_type_t st,
                           output logic [63:0] a, output logic [W-1:0] wd);
        int kind;
        kind = $urandom_range(0, 2);
        ld = (kind != 1) ? mem_load_type_t'(3'($urandom_range(1, 4))) : NO_LOAD;
        st = (kind != 0) ? mem_store_type_t'(3'($urandom_range(1, 4))) : NO_STORE;
        a  = {$urandom, $urandom} & ~64'h3f;
        wd = rand_line();
    endtask

    task automatic drive_agents();
        bit ir, dr;
        mem_rdata = rand_line();
        if (granted_now) lat_cnt = $urandom_range(lat_lo, lat_hi);
        if (owner != 0) begin
            if (hold_l2) mem_ready = 0;
            else if (lat_cnt == 0) mem_ready = 1;
            else begin lat_cnt--; mem_ready = 0; end
        end else begin
            mem_ready = ($urandom_range(0, 99) < idle_pct);
        end
        ir = (i_load_type != NO_LOAD) || (i_store_type != NO_STORE);
        dr = (d_load_type != NO_LOAD) || (d_store_type != NO_STORE);
        if (seen_i) begin
            i_load_type = NO_LOAD; i_store_type = NO_STORE; ir = 0;
            if (keep_busy) begin new_req(i_load_type, i_store_type, i_addr, i_wdata); ir = 1; end
        end
        if (seen_d) begin
            d_load_type = NO_LOAD; d_store_type = NO_STORE; dr = 0;
            if (keep_busy) begin new_req(d_load_type, d_store_type, d_addr, d_wdata); dr = 1; end
        end
        if (auto_l1 && !ir && $urandom_range(0, 99) < 30) new_req(i_load_type, i_store_type, i_addr, i_wdata);
        if (auto_l1 && !dr && $urandom_range(0, 99) < 30) new_req(d_load_type, d_store_type, d_addr, d_wdata);
        if (perturb && $urandom_range(0, 99) < 10) begin i_wdata = rand_line(); i_addr = {$urandom, $urandom}; end
        if (perturb && $urandom_range(0, 99) < 10) begin d_wdata = rand_line(); d_addr = {$urandom, $urandom}; end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        seen_i = (owner == 1) && mem_ready;
        seen_d = (owner == 2) && mem_ready;
        if (i_ready) rdy_log.push_back(1);
        if (d_ready) rdy_log.push_back(2);
        @(posedge clk);
        model_update();
        #1;
        drive_agents();
    endtask

    task automatic clear_inputs();
        i_load_type = NO_LOAD; i_store_type = NO_STORE; i_addr = '0; i_wdata = '0;
        d_load_type = NO_LOAD; d_store_type = NO_STORE; d_addr = '0; d_wdata = '0;
        mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        auto_l1 = 0; keep_busy = 0; perturb = 0; hold_l2 = 0; idle_pct = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        rdy_log.delete();
    endtask

    initial begin
        logic [W-1:0] pat_a5;
        int budget;
        pat_a5 = {64{8'hA5}};

        // Reset values, then a single D load with fixed 3-cycle L2 latency
        do_reset();
        tick();
        d_load_type = LOAD_DWORD; d_addr = 64'h1000;
        lat_lo = 3; lat_hi = 3;
        repeat (10) tick();
        check_val("t1_ready_count", rdy_log.size(), 1);
        if (rdy_log.size() > 0) check_val("t1_ready_port", rdy_log[0], 2);

        // Simultaneous requests after reset: D first, then I; then 4 continuous transactions
        do_reset();
        lat_lo = 1; lat_hi = 2;
        new_req(i_load_type, i_store_type, i_addr, i_wdata);
        new_req(d_load_type, d_store_type, d_addr, d_wdata);
        repeat (15) tick();
        check_val("t2_ready_count", rdy_log.size(), 2);
        if (rdy_log.size() >= 2) begin
            check_val("t2_first", rdy_log[0], 2);
            check_val("t2_second", rdy_log[1], 1);
        end
        rdy_log.delete();
        keep_busy = 1;
        new_req(i_load_type, i_store_type, i_addr, i_wdata);
        new_req(d_load_type, d_store_type, d_addr, d_wdata);
        budget = 0;
        while (rdy_log.size() < 4 && budget < 200) begin tick(); budget++; end
        check_val("t3_ready_count", rdy_log.size() >= 4, 1);
        if (rdy_log.size() >= 4) begin
            check_val("t3_g0", rdy_log[0], 2);
            check_val("t3_g1", rdy_log[1], 1);
            check_val("t3_g2", rdy_log[2], 2);
            check_val("t3_g3", rdy_log[3], 1);
        end
        keep_busy = 0;
        repeat (20) tick();

        // D write-back: latched wdata survives a change of d_wdata mid-grant
        do_reset();
        lat_lo = 6; lat_hi = 6;
        d_store_type = STORE_DWORD; d_addr = 64'h2000; d_wdata = pat_a5;
        repeat (3) tick();
        d_wdata = ~pat_a5;
        tick();
        #1;
        check_val("t4_wdata_held", mem_wdata, pat_a5);
        check_val("t4_store", mem_store_type, STORE_DWORD);
        check_val("t4_addr", mem_addr, 64'h2000);
        repeat (8) tick();

        // Timeout: flag sets after TO grant cycles, sticky across later mem_ready
        do_reset();
        hold_l2 = 1; lat_lo = 0; lat_hi = 0;
        d_load_type = LOAD_WORD; d_addr = 64'h3000;
        tick();
        repeat (TO - 1) tick();
        #1;
        check_val("t5_not_yet", timeout_err, 0);
        tick();
        #1;
        check_val("t5_set", timeout_err, 1);
        repeat (4) tick();
        hold_l2 = 0;
        repeat (6) tick();
        check_val("t5_sticky", timeout_err, 1);
        check_val("t5_done", rdy_log.size(), 1);

        // Reset during GRANT_I: immediate reset outputs, later mem_ready yields no i_ready
        do_reset();
        hold_l2 = 1;
        i_load_type = LOAD_DWORD; i_addr = 64'h4000; i_wdata = rand_line();
        repeat (3) tick();
        #2;
        mem_ready = 1;
        rst = 1;
        #1;
        check_val("t6_i_ready", i_ready, 0);
        check_val("t6_load", mem_load_type, NO_LOAD);
        check_val("t6_store", mem_store_type, NO_STORE);
        check_val("t6_addr", mem_addr, 64'h0);
        check_val("t6_wdata", mem_wdata, '0);
        check_val("t6_err", timeout_err, 0);
        model_reset();
        i_load_type = NO_LOAD;
        @(posedge clk);
        #1;
        rst = 0;
        rdy_log.delete();
        idle_pct = 100;
        repeat (4) tick();
        check_val("t6_no_ready", rdy_log.size(), 0);

        // Randomized traffic with mid-request input perturbation and stray idle mem_ready
        do_reset();
        auto_l1 = 1; perturb = 1; lat_lo = 0; lat_hi = 5; idle_pct = 10;
        repeat (800) tick();
        check_val("rand_progress", rdy_log.size() > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
